// File: rtl/hex_uart_rx.sv
// hex_uart_rx: 8N1 asynchronous serial receiver feeding hex_ram.
// Each correctly framed character is loaded into CHR and announced with a
// one-cycle EN strobe. A stop bit sampled low gives a one-cycle FERR strobe.
// BUSY is high while a frame is in progress.
// Optional build macro HEX_RX_CRLF_FILTER_EN: when defined, correctly framed
// 8'h0A / 8'h0D characters are swallowed (no EN, CHR unchanged).
module hex_uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       RXD,
  output logic [7:0] CHR,
  output logic       EN,
  output logic       FERR,
  output logic       BUSY
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2);

  typedef enum logic [2:0] {
    WAIT_HIGH,
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t          state_reg, state_next;
  logic            rx_meta_reg, rxs_reg;
  logic [1:0]      sync_fill_reg;
  logic [CW-1:0]   cnt_reg;
  logic [2:0]      bit_reg;
  logic [7:0]      shift_reg;
  logic [7:0]      chr_reg;
  logic            en_reg, ferr_reg;
  logic            tick;
  logic            is_term;

  // The counter is loaded with a period length and the sample is taken on
  // the cycle it reads 1, so a load of N samples N cycles later.
  assign tick = (cnt_reg == CW'(1));

`ifdef HEX_RX_CRLF_FILTER_EN
  assign is_term = (shift_reg == 8'h0A) || (shift_reg == 8'h0D);
`else
  assign is_term = 1'b0;
`endif

  // Two-flop synchronizer. The flops reset high, so sync_fill_reg marks when
  // rxs has been refilled from the real line; WAIT_HIGH trusts rxs only after
  // that, otherwise a line held low through reset would look like a start.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      rx_meta_reg   <= 1'b1;
      rxs_reg       <= 1'b1;
      sync_fill_reg <= 2'b00;
    end else begin
      rx_meta_reg   <= RXD;
      rxs_reg       <= rx_meta_reg;
      sync_fill_reg <= {sync_fill_reg[0], 1'b1};
    end
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (CLR) state_reg <= WAIT_HIGH;
    else     state_reg <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      WAIT_HIGH: if (sync_fill_reg[1] && rxs_reg) state_next = IDLE;
      IDLE:      if (!rxs_reg) state_next = START;
      START:     if (tick) state_next = rxs_reg ? IDLE : DATA;
      DATA:      if (tick && (bit_reg == 3'd7)) state_next = STOP;
      STOP:      if (tick) state_next = rxs_reg ? IDLE : WAIT_HIGH;
      default:   state_next = WAIT_HIGH;
    endcase
  end

  // Bit timing, shift register, character latch and strobe registers.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      cnt_reg   <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      chr_reg   <= '0;
      en_reg    <= 1'b0;
      ferr_reg  <= 1'b0;
    end else begin
      en_reg   <= 1'b0;
      ferr_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (!rxs_reg) cnt_reg <= HALF_BIT;
        end
        START: begin
          if (tick) begin
            cnt_reg <= FULL_BIT;
            bit_reg <= 3'd0;
          end else begin
            cnt_reg <= cnt_reg - CW'(1);
          end
        end
        DATA: begin
          if (tick) begin
            shift_reg <= {rxs_reg, shift_reg[7:1]};
            bit_reg   <= bit_reg + 3'd1;
            cnt_reg   <= FULL_BIT;
          end else begin
            cnt_reg <= cnt_reg - CW'(1);
          end
        end
        STOP: begin
          if (tick) begin
            if (rxs_reg) begin
              if (!is_term) begin
                chr_reg <= shift_reg;
                en_reg  <= 1'b1;
              end
            end else begin
              ferr_reg <= 1'b1;
            end
          end else begin
            cnt_reg <= cnt_reg - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode.
  always_comb begin
    CHR  = chr_reg;
    EN   = en_reg;
    FERR = ferr_reg;
    BUSY = (state_reg == START) || (state_reg == DATA) || (state_reg == STOP);
  end

endmodule

// File: tb/tb_hex_uart_rx.sv
// tb_hex_uart_rx: self-checking bench for hex_uart_rx.
// A frame-level model queues the expected outcome of every transmitted frame
// (character strobe or framing error, with its falling-edge time). A monitor
// on the falling clock edge matches every EN/FERR against that queue, checks
// the latency window and checks CHR every cycle.
module tb_hex_uart_rx;

  localparam int P      = 16;
  localparam int H      = P / 2;
  localparam int LAT_LO = 9 * P + H + 2;
  localparam int LAT_HI = 9 * P + H + 4;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       rxd = 1'b0;
  logic [7:0] chr;
  logic       en, ferr, busy;

  hex_uart_rx #(.CLKS_PER_BIT(P)) dut (
    .CLK  (clk),
    .CLR  (clr),
    .RXD  (rxd),
    .CHR  (chr),
    .EN   (en),
    .FERR (ferr),
    .BUSY (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         is_ferr;
    logic [7:0] data;
    int         fall;
  } ev_t;

  ev_t        expq[$];
  ev_t        cur;
  logic [7:0] model_chr = 8'h00;
  int         checks = 0, errors = 0;
  int         en_count = 0, ferr_count = 0;
  int         en_times[$];
  int         busy_run = 0, max_gap = 0;
  bit         seen_busy = 1'b0;

  function automatic void check(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic bit filtered(logic [7:0] b);
`ifdef HEX_RX_CRLF_FILTER_EN
    return (b == 8'h0A) || (b == 8'h0D);
`else
    return 1'b0;
`endif
  endfunction

  // Compare process: runs every cycle outside reset.
  always @(negedge clk) begin
    if (!clr) begin
      check("en_ferr_exclusive", int'(en & ferr), 0);
      if (en || ferr) begin
        if (expq.size() == 0) begin
          check("unexpected_strobe", int'(en | ferr), 0);
        end else begin
          cur = expq.pop_front();
          check("strobe_is_ferr", int'(ferr), int'(cur.is_ferr));
          check("strobe_latency", cyc - cur.fall, (cyc - cur.fall < LAT_LO) ? LAT_LO :
                (cyc - cur.fall > LAT_HI) ? LAT_HI : cyc - cur.fall);
          if (en && !cur.is_ferr) model_chr = cur.data;
        end
      end else if (expq.size() > 0 && (cyc - expq[0].fall > LAT_HI)) begin
        check("missing_strobe", int'(en | ferr), 1);
        void'(expq.pop_front());
      end
      check("chr", int'(chr), int'(model_chr));
      if (en) begin
        en_count++;
        en_times.push_back(cyc);
      end
      if (ferr) ferr_count++;
      if (!busy) begin
        busy_run++;
      end else begin
        if (seen_busy && busy_run > max_gap) max_gap = busy_run;
        seen_busy = 1'b1;
        busy_run  = 0;
      end
    end
  end

  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Transmit one 8N1 frame; the expected outcome is queued first.
  task automatic send_frame(input logic [7:0] b, input bit stop_bit);
    ev_t e;
    e.fall    = cyc;
    e.data    = b;
    e.is_ferr = !stop_bit;
    if (!stop_bit || !filtered(b)) expq.push_back(e);
    rxd = 1'b0;
    tick_n(P);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      tick_n(P);
    end
    rxd = stop_bit;
    tick_n(P);
    rxd = 1'b1;
  endtask

  int e0, f0, s0, bc;
  logic [7:0] rb;
  bit         rstop;
  int         rgap;

  initial begin
    // Test 1: line low through reset and after, then idle, then 0x3A.
    clr = 1'b1;
    rxd = 1'b0;
    tick_n(1);
    check("reset_chr",  int'(chr),  0);
    check("reset_en",   int'(en),   0);
    check("reset_ferr", int'(ferr), 0);
    check("reset_busy", int'(busy), 0);
    tick_n(2);
    clr = 1'b0;
    tick_n(30);
    check("t1_busy_while_low", int'(busy), 0);
    rxd = 1'b1;
    tick_n(2 * P);
    e0 = en_count;
    send_frame(8'h3A, 1'b1);
    tick_n(4);
    check("t1_en_count", en_count - e0, 1);
    check("t1_chr", int'(chr), 8'h3A);
    check("t1_ferr_count", ferr_count, 0);

    // Test 2: three frames back-to-back.
    tick_n(P);
    e0 = en_count;
    s0 = en_times.size();
    seen_busy = 1'b0;
    max_gap   = 0;
    busy_run  = 0;
    send_frame(8'h3A, 1'b1);
    send_frame(8'h31, 1'b1);
    send_frame(8'h30, 1'b1);
    tick_n(4);
    check("t2_en_count", en_count - e0, 3);
    if (en_count - e0 == 3) begin
      check("t2_spacing_a", en_times[s0 + 1] - en_times[s0], 10 * P);
      check("t2_spacing_b", en_times[s0 + 2] - en_times[s0 + 1], 10 * P);
    end
    check("t2_chr", int'(chr), 8'h30);
    check("t2_busy_gap_short", int'(max_gap <= P - H + 1), 1);

    // Test 3: 3-cycle glitch, then 0x45.
    tick_n(P);
    e0 = en_count;
    f0 = ferr_count;
    rxd = 1'b0;
    tick_n(3);
    rxd = 1'b1;
    bc = 0;
    repeat (20) begin
      if (busy) bc++;
      tick_n(1);
    end
    check("t3_busy_seen", int'(bc > 0), 1);
    check("t3_busy_bounded", int'(bc <= 12), 1);
    check("t3_busy_after", int'(busy), 0);
    check("t3_no_en", en_count - e0, 0);
    check("t3_no_ferr", ferr_count - f0, 0);
    send_frame(8'h45, 1'b1);
    tick_n(4);
    check("t3_chr", int'(chr), 8'h45);

    // Test 4: framing error followed by a long break, then 0x42.
    tick_n(P);
    e0 = en_count;
    f0 = ferr_count;
    send_frame(8'h41, 1'b0);
    rxd = 1'b0;
    tick_n(20 * P);
    rxd = 1'b1;
    tick_n(P);
    check("t4_ferr_count", ferr_count - f0, 1);
    check("t4_no_en", en_count - e0, 0);
    check("t4_chr_held", int'(chr), 8'h45);
    send_frame(8'h42, 1'b1);
    tick_n(4);
    check("t4_chr", int'(chr), 8'h42);
    check("t4_en_count", en_count - e0, 1);

    // Test 5: carriage return then 0x46.
    tick_n(P);
    e0 = en_count;
    send_frame(8'h0D, 1'b1);
    tick_n(4);
`ifdef HEX_RX_CRLF_FILTER_EN
    check("t5_chr_after_cr", int'(chr), 8'h42);
`else
    check("t5_chr_after_cr", int'(chr), 8'h0D);
`endif
    tick_n(P);
    send_frame(8'h46, 1'b1);
    tick_n(4);
    check("t5_chr", int'(chr), 8'h46);
`ifdef HEX_RX_CRLF_FILTER_EN
    check("t5_en_count", en_count - e0, 1);
`else
    check("t5_en_count", en_count - e0, 2);
`endif

    // Test 6: reset during data bit 4 of 0x55; the transmitter aborts too.
    tick_n(P);
    rb = 8'h55;
    rxd = 1'b0;
    tick_n(P);
    for (int i = 0; i < 4; i++) begin
      rxd = rb[i];
      tick_n(P);
    end
    rxd = rb[4];
    tick_n(H);
    clr = 1'b1;
    expq.delete();
    model_chr = 8'h00;
    tick_n(1);
    clr = 1'b0;
    check("t6_chr_reset", int'(chr), 0);
    check("t6_en_reset", int'(en), 0);
    check("t6_busy_reset", int'(busy), 0);
    rxd = 1'b1;
    e0 = en_count;
    f0 = ferr_count;
    tick_n(2 * P);
    check("t6_no_strobe_en", en_count - e0, 0);
    check("t6_no_strobe_ferr", ferr_count - f0, 0);
    send_frame(8'h33, 1'b1);
    tick_n(4);
    check("t6_chr", int'(chr), 8'h33);
    check("t6_en_count", en_count - e0, 1);

    // Randomized traffic against the frame-level model.
    for (int n = 0; n < 40; n++) begin
      rb    = 8'($urandom_range(0, 255));
      rstop = ($urandom_range(0, 7) != 0);
      rgap  = rstop ? int'($urandom_range(0, 20)) : P + int'($urandom_range(0, 20));
      send_frame(rb, rstop);
      tick_n(rgap);
    end

    tick_n(2 * P);
    check("queue_drained", expq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
